// File: rtl/mul_pkg.sv
// Shared types and defaults for the iterative shift-add multiplier.
// Defaults give one multiplier bit per cycle, so a 16x16 product takes 16 RUN cycles.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int MUL_WIDTH = 16;
  localparam int MUL_BPC   = 1;
  localparam int MUL_ITER  = MUL_WIDTH / MUL_BPC;

  // A radix is legal only if it retires the multiplier in a whole number of steps.
  function automatic bit radix_ok(input int width, input int bpc);
    return (bpc > 0) && (bpc <= width) && ((width % bpc) == 0);
  endfunction

endpackage

// File: rtl/mul_pp_step.sv
// One radix-2^B shift-add step: adds mcand*slice into the upper-aligned accumulator, then shifts right by B.
// Purely combinational; the accumulator carries B spare bits so the add never overflows.
module mul_pp_step #(
  parameter int W = 16,
  parameter int B = 1
) (
  input  logic [2*W+B-1:0] acc,
  input  logic [W-1:0]     mcand,
  input  logic [B-1:0]     slice,
  output logic [2*W+B-1:0] acc_nxt
);

  localparam int AW = 2*W + B;

  logic [AW-1:0] pp;
  logic [AW-1:0] sum;

  assign pp      = AW'(mcand) * AW'(slice);
  // Partial products enter at bit W; ITER right shifts bring step i down to bit i*B.
  assign sum     = acc + (pp << W);
  assign acc_nxt = sum >> B;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative unsigned multiplier: start in IDLE/DONE, RUN for WIDTH/BITS_PER_CYCLE cycles, one-cycle done pulse.
// Latency ITER+1 cycles from start; start during RUN is ignored and mulresult holds until the next completion.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH          = MUL_WIDTH,
  parameter int BITS_PER_CYCLE = MUL_BPC
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mul1,
  input  logic [WIDTH-1:0]     mul2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   mulresult
);

  localparam int ITER = WIDTH / BITS_PER_CYCLE;
  localparam int AW   = 2*WIDTH + BITS_PER_CYCLE;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  if (!radix_ok(WIDTH, BITS_PER_CYCLE)) begin : g_bad_radix
    $error("seq_multiplier: BITS_PER_CYCLE must divide WIDTH");
  end

  mul_state_t         state;
  mul_state_t         state_nxt;
  logic [AW-1:0]      acc;
  logic [AW-1:0]      acc_step;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic               last;

  mul_pp_step #(
    .W (WIDTH),
    .B (BITS_PER_CYCLE)
  ) u_step (
    .acc     (acc),
    .mcand   (mcand),
    .slice   (mplier[BITS_PER_CYCLE-1:0]),
    .acc_nxt (acc_step)
  );

  assign last = (count == LAST);
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operands are captured only on acceptance, so changes on mul1/mul2 mid-RUN are invisible.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
      mulresult <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand  <= mul1;
            mplier <= mul2;
            acc    <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          acc    <= acc_step;
          mplier <= mplier >> BITS_PER_CYCLE;
          count  <= count + CW'(1);
          if (last) mulresult <= acc_step[2*WIDTH-1:0];
        end
        default: begin
          acc   <= '0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench: five multipliers (BITS_PER_CYCLE 1,2,4,8,16) share clk/rstn; expected products
// are queued at issue and popped by a per-instance monitor whenever done is seen.
module tb_seq_multiplier;

  localparam int N = 5;

  logic             clk;
  logic             rstn;
  logic [N-1:0]     start_v;
  logic [N-1:0]     busy_v;
  logic [N-1:0]     done_v;
  logic [15:0]      m1_a  [N];
  logic [15:0]      m2_a  [N];
  logic [31:0]      res_a [N];
  logic [31:0]      exp_q [N][$];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
    return 32'(a) * 32'(b);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    seq_multiplier #(
      .WIDTH          (16),
      .BITS_PER_CYCLE (1 << g)
    ) u_dut (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start_v[g]),
      .mul1      (m1_a[g]),
      .mul2      (m2_a[g]),
      .busy      (busy_v[g]),
      .done      (done_v[g]),
      .mulresult (res_a[g])
    );

    always @(negedge clk) begin
      if (done_v[g]) begin
        chk($sformatf("busy_with_done[%0d]", g), 32'(busy_v[g]), 32'd0);
        if (exp_q[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done[%0d]: got done=1 expected no operation pending at %0t", g, $time);
        end else begin
          chk($sformatf("product[%0d]", g), res_a[g], exp_q[g].pop_front());
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input logic [15:0] a, input logic [15:0] b);
    m1_a[i]    = a;
    m2_a[i]    = b;
    start_v[i] = 1'b1;
    exp_q[i].push_back(model(a, b));
  endtask

  // Issues one op in the current cycle and checks busy/done timing plus mulresult stability.
  task automatic run_timed(input int i, input logic [15:0] a, input logic [15:0] b,
                           input int iter, input string nm);
    logic [31:0] prev;
    prev = res_a[i];
    issue(i, a, b);
    for (int c = 1; c <= iter + 1; c++) begin
      nxt();
      if (c == 1) start_v[i] = 1'b0;
      @(negedge clk);
      chk({nm, "_busy"}, 32'(busy_v[i]), 32'(c <= iter));
      chk({nm, "_done"}, 32'(done_v[i]), 32'(c == iter + 1));
      if (c <= iter) chk({nm, "_hold"}, res_a[i], prev);
    end
    nxt();
  endtask

  initial begin
    logic [31:0] first;
    logic [15:0] a, b;
    int          seen;
    int          k;

    rstn    = 1'b0;
    start_v = '0;
    for (int i = 0; i < N; i++) begin
      m1_a[i] = '0;
      m2_a[i] = '0;
    end
    nxt();
    nxt();
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_busy[%0d]", i), 32'(busy_v[i]), 32'd0);
      chk($sformatf("rst_done[%0d]", i), 32'(done_v[i]), 32'd0);
      chk($sformatf("rst_res[%0d]", i), res_a[i], 32'd0);
    end
    nxt();

    run_timed(0, 16'd3, 16'd5, 16, "basic");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("basic_held", res_a[0], 32'h0000_000F);
      nxt();
    end

    run_timed(0, 16'hFFFF, 16'hFFFF, 16, "max");
    run_timed(0, 16'h0000, 16'h1234, 16, "zero");

    // start held through RUN, new operands in the DONE cycle -> back-to-back op
    first = model(16'h0011, 16'h0022);
    issue(0, 16'h0011, 16'h0022);
    for (int c = 1; c <= 16; c++) begin
      nxt();
      m1_a[0] = 16'($urandom);
      m2_a[0] = 16'($urandom);
      @(negedge clk);
      chk("held_start_busy", 32'(busy_v[0]), 32'd1);
      chk("held_start_done", 32'(done_v[0]), 32'd0);
    end
    nxt();
    issue(0, 16'h0100, 16'h0100);
    @(negedge clk);
    chk("b2b_first_done", 32'(done_v[0]), 32'd1);
    for (int c = 18; c <= 34; c++) begin
      nxt();
      if (c == 18) start_v[0] = 1'b0;
      @(negedge clk);
      chk("b2b_busy", 32'(busy_v[0]), 32'(c <= 33));
      chk("b2b_done", 32'(done_v[0]), 32'(c == 34));
      if (c < 34) chk("b2b_first_stable", res_a[0], first);
    end
    chk("b2b_second_value", res_a[0], 32'h0001_0000);
    nxt();

    // reset during RUN: operation discarded, no done, result cleared
    m1_a[0]    = 16'd7;
    m2_a[0]    = 16'd9;
    start_v[0] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      nxt();
      if (c == 1) start_v[0] = 1'b0;
      if (c == 8) rstn = 1'b0;
      @(negedge clk);
      chk("midrst_busy_before", 32'(busy_v[0]), 32'd1);
    end
    nxt();
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_busy_after", 32'(busy_v[0]), 32'd0);
    chk("midrst_res", res_a[0], 32'd0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      nxt();
      @(negedge clk);
      if (done_v[0]) seen++;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    nxt();

    run_timed(2, 16'h1234, 16'h5678, 4, "radix4");
    @(negedge clk);
    chk("radix4_value", res_a[2], 32'h0626_0060);
    nxt();

    // random sweep, all radices in lockstep
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < N; i++) begin
        k = int'($urandom_range(0, 7));
        a = (k == 0) ? 16'h0000 : (k == 1) ? 16'hFFFF : 16'($urandom);
        k = int'($urandom_range(0, 7));
        b = (k == 0) ? 16'h0000 : (k == 1) ? 16'hFFFF : 16'($urandom);
        issue(i, a, b);
      end
      nxt();
      start_v = '0;
      k = 0;
      @(negedge clk);
      while (!done_v[0] && k < 40) begin
        @(negedge clk);
        k++;
      end
      if (k >= 40) begin
        chk("sweep_timeout", 32'(k), 32'd39);
        break;
      end
      nxt();
    end

    for (int i = 0; i < N; i++)
      chk($sformatf("pending_at_end[%0d]", i), 32'(exp_q[i].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
